// File: rtl/nonce_uart_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nonce_uart_packer_pkg
//  Purpose  : Shared constants and FSM encoding for the nonce-to-UART packer.
//             NONCE_W must equal the miner's result-word width.
//  Revision : 1.0  initial release
// ============================================================================
package nonce_uart_packer_pkg;

  // One golden nonce is four bytes on the line
  localparam int NONCE_W            = 32;
  localparam int BYTE_W             = 8;
  localparam int NONCE_BYTES        = NONCE_W / BYTE_W;
  localparam int DEFAULT_DEPTH_LOG2 = 2;

  // Index of the byte currently being handed to the transmitter
  localparam int                    BYTE_IDX_W    = 2;
  localparam logic [BYTE_IDX_W-1:0] BYTE_IDX_ONE  = BYTE_IDX_W'(1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(NONCE_BYTES - 1);

  // Serialiser FSM encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage : nonce_uart_packer_pkg
`default_nettype wire

// File: rtl/nonce_uart_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : nonce_uart_packer_if
//  Purpose  : Result-word input and transmitter byte handshake of the packer.
//             master = packer side, slave = hashing core / transmitter side.
//  Revision : 1.0  initial release
// ============================================================================
interface nonce_uart_packer_if
  import nonce_uart_packer_pkg::*;
();

  logic               nonce_valid;
  logic [NONCE_W-1:0] nonce;
  logic               tx_ready;
  logic               tx_new_byte;
  logic [BYTE_W-1:0]  tx_byte;

  modport master (
    input  nonce_valid,
    input  nonce,
    input  tx_ready,
    output tx_new_byte,
    output tx_byte
  );

  modport slave (
    output nonce_valid,
    output nonce,
    output tx_ready,
    input  tx_new_byte,
    input  tx_byte
  );

endinterface : nonce_uart_packer_if
`default_nettype wire

// File: rtl/nonce_uart_packer_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO of 2**DEPTH_LOG2 words. A push while full is
//             accepted only when a pop happens in the same cycle; otherwise it
//             is ignored (the caller flags the loss).
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // When full, the slot being written is the head being popped this cycle;
  // the old head is read before the write lands, so the overwrite is safe.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/nonce_uart_packer.sv
`default_nettype none
// ============================================================================
//  Module   : nonce_uart_packer
//  Purpose  : Buffers golden nonces and serialises each one as four bytes,
//             MSB first, onto the UART transmitter's byte handshake.
//  Revision : 1.0  initial release
// ============================================================================
module nonce_uart_packer
  import nonce_uart_packer_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int WORD_W     = NONCE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nonce_uart_packer_if.master  bus,
  output logic [DEPTH_LOG2:0]  fifo_count,
  output logic                 overflow,
  output logic                 busy
);

  state_t                  state_q, state_d;
  logic [WORD_W-1:0]       shift_q, shift_d;
  logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic                    tx_new_byte_q, tx_new_byte_d;
  logic [BYTE_W-1:0]       tx_byte_q, tx_byte_d;
  logic                    overflow_q, overflow_d;

  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [WORD_W-1:0]       fifo_rd_data;

  // The FSM takes the next word only from IDLE, one cycle after a word ends
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (bus.nonce_valid),
    .pop     (fifo_pop),
    .wr_data (bus.nonce),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next-state, shifter and byte-strobe logic
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    byte_idx_d    = byte_idx_q;
    tx_new_byte_d = 1'b0;
    tx_byte_d     = tx_byte_q;
    overflow_d    = overflow_q | (bus.nonce_valid & fifo_full & ~fifo_pop);
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          shift_d    = fifo_rd_data;
          byte_idx_d = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        // Gating on our own strobe keeps pulses at least one cycle apart even
        // if the transmitter is slow to drop tx_ready.
        if (bus.tx_ready && !tx_new_byte_q) begin
          tx_new_byte_d = 1'b1;
          tx_byte_d     = shift_q[WORD_W-1 -: BYTE_W];
          shift_d       = {shift_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
          byte_idx_d    = byte_idx_q + BYTE_IDX_ONE;
          if (byte_idx_q == LAST_BYTE_IDX) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Serialiser state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      byte_idx_q    <= '0;
      tx_new_byte_q <= 1'b0;
      tx_byte_q     <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      byte_idx_q    <= byte_idx_d;
      tx_new_byte_q <= tx_new_byte_d;
      tx_byte_q     <= tx_byte_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.tx_new_byte = tx_new_byte_q;
  assign bus.tx_byte     = tx_byte_q;
  assign overflow        = overflow_q;
  assign busy            = !fifo_empty || (state_q != ST_IDLE);

endmodule : nonce_uart_packer
`default_nettype wire

// File: tb/tb_nonce_uart_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nonce_uart_packer
//  Purpose  : Self-checking bench for nonce_uart_packer with a stub
//             transmitter and a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nonce_uart_packer;

  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk;
  logic                rst_n;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                overflow;
  logic                busy;

  nonce_uart_packer_if bus_if ();

  nonce_uart_packer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: words waiting, bytes of the word being sent, last strobe
  logic [31:0] m_q[$];
  logic [7:0]  m_bytes[$];
  bit          m_pulse;
  logic [7:0]  m_byte;
  bit          m_ovf;

  int          stub_cnt;
  bit          prev_pulse;
  int          peak_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_bytes.delete();
    m_pulse = 1'b0;
    m_byte  = 8'h00;
    m_ovf   = 1'b0;
  endtask

  // One clock edge of the specified behaviour, on the inputs seen at that edge
  task automatic model_edge(input bit v, input logic [31:0] n, input bit rdy);
    bit          pop;
    bit          np;
    int          sz;
    logic [31:0] w;
    pop = (m_bytes.size() == 0) && (m_q.size() > 0);
    sz  = m_q.size();
    np  = 1'b0;
    if (m_bytes.size() > 0 && rdy && !m_pulse) begin
      np     = 1'b1;
      m_byte = m_bytes.pop_front();
    end
    m_pulse = np;
    if (pop) begin
      w = m_q.pop_front();
      for (int b = 0; b < 4; b++) m_bytes.push_back(w[31-8*b -: 8]);
    end
    if (v) begin
      if (sz < DEPTH || pop) m_q.push_back(n);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic compare_all();
    chk("tx_new_byte", {31'd0, bus_if.tx_new_byte}, {31'd0, m_pulse});
    chk("tx_byte", {24'd0, bus_if.tx_byte}, {24'd0, m_byte});
    chk("fifo_count", {29'd0, fifo_count}, m_q.size());
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("busy", {31'd0, busy}, {31'd0, (m_q.size() > 0 || m_bytes.size() > 0)});
    chk("back_to_back", {31'd0, prev_pulse & bus_if.tx_new_byte}, 32'd0);
    prev_pulse = bus_if.tx_new_byte;
    if (int'(fifo_count) > peak_count) peak_count = int'(fifo_count);
  endtask

  // One cycle: called at a negedge, drives inputs, steps the model, checks
  task automatic cycle(input bit v, input logic [31:0] n, input bit hold);
    bit rdy;
    if (bus_if.tx_new_byte) stub_cnt = $urandom_range(1, 6);
    else if (stub_cnt > 0) stub_cnt--;
    rdy = !hold && (stub_cnt == 0) && !bus_if.tx_new_byte;
    bus_if.nonce_valid = v;
    bus_if.nonce       = n;
    bus_if.tx_ready    = rdy;
    @(posedge clk);
    model_edge(v, n, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tx_new_byte"}, {31'd0, bus_if.tx_new_byte}, 32'd0);
    chk({tag, "_tx_byte"}, {24'd0, bus_if.tx_byte}, 32'd0);
    chk({tag, "_fifo_count"}, {29'd0, fifo_count}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Asserts reset between edges, checks outputs at once, releases at a negedge
  task automatic apply_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_values(tag);
    model_reset();
    prev_pulse = 1'b0;
    bus_if.nonce_valid = 1'b0;
    bus_if.tx_ready    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((m_q.size() > 0 || m_bytes.size() > 0) && k < 500) begin
      cycle(1'b0, 32'h0, 1'b0);
      k++;
    end
    chk({tag, "_drain_timeout"}, {31'd0, (k >= 500)}, 32'd0);
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    int k;
    rst_n              = 1'b0;
    bus_if.nonce_valid = 1'b0;
    bus_if.nonce       = '0;
    bus_if.tx_ready    = 1'b0;
    stub_cnt           = 0;
    prev_pulse         = 1'b0;
    peak_count         = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;

    // Single nonce: first strobe in the cycle after edge N+2
    cycle(1'b1, 32'hDEADBEEF, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("latency_first_byte", {31'd0, bus_if.tx_new_byte}, 32'd1);
    chk("first_byte_de", {24'd0, bus_if.tx_byte}, 32'h0000_00DE);
    drain("single");

    // Burst of four back-to-back: head popped, three buffered
    peak_count = 0;
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0);
    drain("burst4");
    chk("burst4_peak_count", peak_count, 32'd3);
    chk("burst4_overflow", {31'd0, overflow}, 32'd0);

    // Burst of six: sixth word lost, overflow sticky
    for (int i = 1; i <= 6; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0);
    drain("burst6");
    chk("burst6_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Push while full in the same cycle as the IDLE pop
    apply_reset("rst_a");
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hA000_0000 + 32'(i), 1'b1);
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    k = 0;
    while (!(m_bytes.size() == 0 && m_q.size() == DEPTH) && k < 200) begin
      cycle(1'b0, 32'h0, 1'b0);
      k++;
    end
    chk("full_pop_wait_timeout", {31'd0, (k >= 200)}, 32'd0);
    cycle(1'b1, 32'hB0B0_B0B0, 1'b0);
    chk("push_pop_full_count", {29'd0, fifo_count}, 32'd4);
    chk("push_pop_full_overflow", {31'd0, overflow}, 32'd0);
    drain("pushpop");

    // Transmitter stalled for 1000 cycles in the middle of a word
    cycle(1'b1, 32'h0BAD_F00D, 1'b0);
    k = 0;
    while (m_bytes.size() != 2 && k < 200) begin
      cycle(1'b0, 32'h0, 1'b0);
      k++;
    end
    chk("stall_setup_timeout", {31'd0, (k >= 200)}, 32'd0);
    repeat (1000) cycle(1'b0, 32'h0, 1'b1);
    drain("stall");

    // Reset after the second byte of a word, then a clean new word
    cycle(1'b1, 32'h12345678, 1'b0);
    k = 0;
    while (m_bytes.size() != 2 && k < 200) begin
      cycle(1'b0, 32'h0, 1'b0);
      k++;
    end
    chk("midword_setup_timeout", {31'd0, (k >= 200)}, 32'd0);
    apply_reset("rst_mid");
    cycle(1'b1, 32'hCAFEF00D, 1'b0);
    drain("after_reset");

    // Random traffic with a jittery transmitter and occasional stalls
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 15) == 0);
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_nonce_uart_packer
`default_nettype wire
